fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clock and async_reset.
REQ-002 clock  input  1  rising-edge clock for the PC register.
REQ-003 async_reset  input  1  asynchronous, active-high reset of the PC register.
REQ-004 PC_source_E  input  2  Execute-stage next-PC select: 00 sequential/prediction, 01 ALU target, 10 Execute PC+4 recovery, 11 reserved.
REQ-005 PC_plus_4_E  input  32  PC+4 of the instruction in Execute, used for misprediction recovery.
REQ-006 ALU_result_0_E  input  32  computed jump/branch target from Execute.
REQ-007 enable_fetch  input  1  PC register load enable; 0 stalls fetch.
REQ-008 branch_prediction_D  input  1  Decode-stage predicted-taken flag.
REQ-009 predicted_PC_D  input  32  Decode-stage predicted target address.
REQ-010 PC_F  output  32  current fetch address (register output).
REQ-011 PC_plus_4_F  output  32  PC_F + 4 (combinational).

Function
REQ-012 The block SHALL compute next_PC combinationally with this priority: PC_source_E=01 -> ALU_result_0_E; PC_source_E=10 -> PC_plus_4_E; else branch_prediction_D=1 -> predicted_PC_D; else PC_plus_4_F.
REQ-013 The block SHALL treat PC_source_E=11 exactly as 00.
REQ-014 An Execute redirect (01 or 10) SHALL override a simultaneous Decode prediction.
REQ-015 On a rising clock edge with enable_fetch=1 and reset deasserted, PC_F SHALL load next_PC, giving one-cycle latency from select inputs to PC_F.
REQ-016 With enable_fetch=0, PC_F SHALL hold its value, including when a redirect or prediction is present.
REQ-017 PC_plus_4_F SHALL equal PC_F + 4 modulo 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000.
REQ-018 The block SHALL not modify address bits; targets SHALL be loaded unaltered, including misaligned values.
REQ-019 The block SHALL hold no state other than the 32-bit PC register.

Reset
REQ-020 While async_reset=1, PC_F SHALL be 0x0000_0000 immediately, independent of clock, and PC_plus_4_F SHALL be 0x0000_0004.
REQ-021 Reset SHALL take precedence over enable_fetch and all select inputs.
REQ-022 After reset deasserts, the first rising edge with enable_fetch=1 SHALL load next_PC.
REQ-023 Reset asserted mid-operation SHALL force PC_F to 0 at once, discarding any pending redirect.

Configuration
REQ-024 When macro FETCH_MISALIGN_CHECK_EN is defined, the block SHALL add output misaligned_F (1 bit), high whenever PC_F[1:0] != 00 and 0 during reset.
REQ-025 Without FETCH_MISALIGN_CHECK_EN, port misaligned_F SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-026 Reset: async_reset=1 between clock edges -> PC_F=0x0 and PC_plus_4_F=0x4 immediately; no change while held.
REQ-027 Sequential: reset released, enable=1, sel=00, pred=0, 3 edges -> PC_F 0x4, 0x8, 0xC.
REQ-028 ALU redirect: sel=01, ALU_result_0_E=0x10, pred=1, predicted_PC_D=0x8 -> PC_F=0x10 after one edge, PC_plus_4_F=0x14.
REQ-029 Stall: enable=0, sel=10, PC_plus_4_E=0x20 -> PC_F unchanged over 2 edges; then enable=1 -> PC_F=0x20.
REQ-030 Prediction and reserved select: sel=11, pred=1, predicted_PC_D=0x100 -> PC_F=0x100; then pred=0 -> PC_F=0x104.
REQ-031 Wrap and misalign check: load ALU target 0xFFFF_FFFC -> PC_plus_4_F=0x0; load 0x2 -> misaligned_F=1 (macro defined only).

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch PC register and next-PC selection.
//
// Holds the 32-bit fetch PC and picks the next fetch address each cycle.
// Execute-stage redirects (ALU target or PC+4 recovery) win over a Decode
// prediction, which wins over plain sequential fetch. Addresses pass through
// unaltered; misaligned targets are loaded as given.
//
// Ports:
//   clock               rising-edge clock for the PC register
//   async_reset         asynchronous active-high reset, PC_F -> 0
//   PC_source_E[1:0]    00/11 seq/prediction, 01 ALU target, 10 Execute PC+4
//   PC_plus_4_E[31:0]   PC+4 of the Execute instruction (mispredict recovery)
//   ALU_result_0_E[31:0] computed jump/branch target from Execute
//   enable_fetch        PC load enable, 0 stalls fetch
//   branch_prediction_D Decode predicted-taken flag
//   predicted_PC_D[31:0] Decode predicted target
//   PC_F[31:0]          current fetch address (registered)
//   PC_plus_4_F[31:0]   PC_F + 4, wraps modulo 2^32
//   misaligned_F        PC_F[1:0] != 0 (only with FETCH_MISALIGN_CHECK_EN)
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN adds misaligned_F.
module fetch_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            async_reset,
  input  logic [1:0]      PC_source_E,
  input  logic [XLEN-1:0] PC_plus_4_E,
  input  logic [XLEN-1:0] ALU_result_0_E,
  input  logic            enable_fetch,
  input  logic            branch_prediction_D,
  input  logic [XLEN-1:0] predicted_PC_D,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic            misaligned_F,
`endif
  output logic [XLEN-1:0] PC_F,
  output logic [XLEN-1:0] PC_plus_4_F
);

  localparam logic [1:0] SRC_ALU     = 2'b01;
  localparam logic [1:0] SRC_RECOVER = 2'b10;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
  } redirect_t;

  redirect_t       exe_redirect;
  logic [XLEN-1:0] next_pc;

  // Sequential address; carry out of bit XLEN-1 is dropped so the top word wraps to 0.
  assign PC_plus_4_F = PC_F + XLEN'(4);

  // Execute redirect. Select 11 is reserved and behaves like 00 (no redirect).
  always_comb begin
    exe_redirect = '0;
    case (PC_source_E)
      SRC_ALU:     exe_redirect = '{taken: 1'b1, target: ALU_result_0_E};
      SRC_RECOVER: exe_redirect = '{taken: 1'b1, target: PC_plus_4_E};
      default:     exe_redirect = '0;
    endcase
  end

  always_comb begin
    next_pc = PC_plus_4_F;
    if (exe_redirect.taken)       next_pc = exe_redirect.target;
    else if (branch_prediction_D) next_pc = predicted_PC_D;
  end

  always_ff @(posedge clock or posedge async_reset) begin
    if (async_reset)       PC_F <= '0;
    else if (enable_fetch) PC_F <= next_pc;
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // PC_F is zero during reset, so this is low then without extra gating.
  assign misaligned_F = |PC_F[1:0];
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// traffic compared against an address-level reference model.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        async_reset;
  logic [1:0]  PC_source_E;
  logic [31:0] PC_plus_4_E, ALU_result_0_E, predicted_PC_D;
  logic        enable_fetch, branch_prediction_D;
  logic [31:0] PC_F, PC_plus_4_F;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misaligned_F;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model_pc;

  always #5 clock = ~clock;

  fetch_stage dut (
    .clock               (clock),
    .async_reset         (async_reset),
    .PC_source_E         (PC_source_E),
    .PC_plus_4_E         (PC_plus_4_E),
    .ALU_result_0_E      (ALU_result_0_E),
    .enable_fetch        (enable_fetch),
    .branch_prediction_D (branch_prediction_D),
    .predicted_PC_D      (predicted_PC_D),
`ifdef FETCH_MISALIGN_CHECK_EN
    .misaligned_F        (misaligned_F),
`endif
    .PC_F                (PC_F),
    .PC_plus_4_F         (PC_plus_4_F)
  );

  // Architectural next-PC rule: Execute redirect beats prediction beats PC+4.
  function automatic logic [31:0] ref_next(input logic [31:0] pc);
    if (PC_source_E == 2'd1)      return ALU_result_0_E;
    if (PC_source_E == 2'd2)      return PC_plus_4_E;
    if (branch_prediction_D)      return predicted_PC_D;
    return pc + 32'd4;
  endfunction

  // One rising edge; model advances exactly as the architecture says, then
  // outputs are sampled 1 time unit after the edge.
  task automatic step();
    logic [31:0] nxt;
    nxt = ref_next(model_pc);
    @(posedge clock);
    if (!async_reset && enable_fetch) model_pc = nxt;
    else if (async_reset) model_pc = 32'd0;
    #1;
  endtask

  task automatic set_in(input logic [1:0] sel, input logic [31:0] p4e,
                        input logic [31:0] alu, input logic en,
                        input logic pred, input logic [31:0] ppc);
    PC_source_E = sel; PC_plus_4_E = p4e; ALU_result_0_E = alu;
    enable_fetch = en; branch_prediction_D = pred; predicted_PC_D = ppc;
  endtask

  task automatic chk_pc(input string name, input logic [31:0] exp_pc);
    n_cmp++;
    if (PC_F !== exp_pc || PC_plus_4_F !== exp_pc + 32'd4) begin
      n_err++;
      $display("FAIL %s: PC_F=%h PC_plus_4_F=%h, required %h / %h",
               name, PC_F, PC_plus_4_F, exp_pc, exp_pc + 32'd4);
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    n_cmp++;
    if (misaligned_F !== (exp_pc[1:0] != 2'b00)) begin
      n_err++;
      $display("FAIL %s misaligned: got %b, required %b", name, misaligned_F,
               exp_pc[1:0] != 2'b00);
    end
`endif
  endtask

  task automatic test_reset();
    set_in(2'd1, 32'h20, 32'h1234, 1'b1, 1'b1, 32'h88);
    async_reset = 1'b0;
    step(); step();            // PC leaves 0 before the async reset
    @(negedge clock); #2;      // between edges
    async_reset = 1'b1; model_pc = 32'd0;
    #1;
    chk_pc("reset_immediate", 32'd0);
    step(); step();
    chk_pc("reset_held", 32'd0);
  endtask

  task automatic test_sequential();
    set_in(2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clock); async_reset = 1'b0;
    step(); chk_pc("seq_1", 32'h4);
    step(); chk_pc("seq_2", 32'h8);
    step(); chk_pc("seq_3", 32'hC);
  endtask

  task automatic test_alu_redirect();
    set_in(2'd1, 32'h0, 32'h10, 1'b1, 1'b1, 32'h8);
    step(); chk_pc("alu_redirect", 32'h10);
  endtask

  task automatic test_stall();
    set_in(2'd2, 32'h20, 32'h0, 1'b0, 1'b1, 32'h300);
    step(); chk_pc("stall_1", 32'h10);
    step(); chk_pc("stall_2", 32'h10);
    enable_fetch = 1'b1;
    step(); chk_pc("stall_release", 32'h20);
  endtask

  task automatic test_prediction();
    set_in(2'd3, 32'h0, 32'h44, 1'b1, 1'b1, 32'h100);
    step(); chk_pc("predict_sel11", 32'h100);
    branch_prediction_D = 1'b0;
    step(); chk_pc("seq_sel11", 32'h104);
  endtask

  task automatic test_wrap_misalign();
    set_in(2'd1, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0);
    step(); chk_pc("wrap_load", 32'hFFFF_FFFC);
    n_cmp++;
    if (PC_plus_4_F !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_plus4: got %h, required 00000000", PC_plus_4_F);
    end
    PC_source_E = 2'd0;
    step(); chk_pc("wrap_seq", 32'h0);
    set_in(2'd1, 32'h0, 32'h2, 1'b1, 1'b0, 32'h0);
    step(); chk_pc("misaligned_load", 32'h2);
  endtask

  task automatic test_reset_midop();
    set_in(2'd1, 32'h0, 32'hABC0, 1'b1, 1'b1, 32'h40);
    @(negedge clock);
    async_reset = 1'b1; model_pc = 32'd0;
    #1;
    chk_pc("midop_reset", 32'd0);
    step(); chk_pc("midop_reset_edge", 32'd0);
    @(negedge clock); async_reset = 1'b0;
    step(); chk_pc("first_edge_after_reset", 32'hABC0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      set_in(2'($urandom_range(0, 3)), $urandom, $urandom,
             ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom);
      step();
      chk_pc("random", model_pc);
      @(negedge clock);
    end
  endtask

  initial begin
    async_reset = 1'b1;
    model_pc = 32'd0;
    set_in(2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk_pc("power_on_reset", 32'd0);
    test_reset();
    test_sequential();
    test_alu_redirect();
    test_stall();
    test_prediction();
    test_wrap_misalign();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
